booth8_seq_mult: RTL and testbench

Sequential radix-8 Booth multiplier core that consumes the precomputed multiples 1M, 2M, 3M and 4M of an unsigned multiplicand and the unsigned multiplier N. It produces the 2·pN-bit unsigned product. It is the receiving end of the multiple-precompute stage in the unsigned approximate-multiplier datapath. A run-time truncation input zeroes the low Booth digits, trading accuracy for switching activity; setting it to 0 recovers the exact result.

---
 rtl/booth8_pkg.sv | 21 ++
 rtl/booth8_digit_sel.sv | 27 ++
 rtl/booth8_seq_mult.sv | 115 +++++++++++
 tb/tb_booth8_seq_mult.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth8_pkg.sv
// Shared types and sizing helpers for the sequential radix-8 Booth multiplier.
// Digit count follows from the operand width plus the implicit bm1 bit.
package booth8_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  // Booth digit in sign-magnitude form; magnitude 0..4 indexes the multiples.
  typedef struct packed {
    logic       neg;
    logic [2:0] mag;
  } booth_digit_t;

  function automatic int booth8_digits(input int w);
    return (w + 3) / 3;
  endfunction

  function automatic int booth8_cnt_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/booth8_digit_sel.sv
// Radix-8 Booth recoder: four raw multiplier bits (b2 b1 b0 bm1) to sign/magnitude.
// A set trunc flag forces the digit to zero.
module booth8_digit_sel
  import booth8_pkg::*;
(
  input  logic [3:0]   raw,
  input  logic         trunc,
  output booth_digit_t dig
);

  logic [2:0] sum;

  // value = -4*b2 + (2*b1 + b0 + bm1); the positive part never exceeds 4
  always_comb begin
    sum = {1'b0, raw[2], 1'b0} + {2'b00, raw[1]} + {2'b00, raw[0]};
    dig = '0;
    if (!trunc) begin
      if (raw[3]) begin
        dig.mag = 3'd4 - sum;
        dig.neg = (sum != 3'd4);
      end else begin
        dig.mag = sum;
      end
    end
  end

endmodule

// File: rtl/booth8_seq_mult.sv
// Sequential radix-8 Booth multiplier: one digit per cycle, MSB-first Horner
// accumulation over precomputed multiples 1M..4M, with low-digit truncation.
module booth8_seq_mult
  import booth8_pkg::*;
#(
  parameter int pN = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Ld,
  input  logic [pN-1:0]     N,
  input  logic [pN+3:0]     P1,
  input  logic [pN+3:0]     P2,
  input  logic [pN+3:0]     P3,
  input  logic [pN+3:0]     P4,
  input  logic [2:0]        Trunc,
  output logic [2*pN-1:0]   P,
  output logic              Valid,
  output logic              Busy
);

  localparam int D  = booth8_digits(pN);
  localparam int XW = 3 * D + 1;
  localparam int AW = 2 * pN + 4;
  localparam int MW = pN + 4;
  localparam int KW = booth8_cnt_w(D);
  localparam logic [KW-1:0] K_LAST = KW'(D - 1);

  state_t               state;
  logic [KW-1:0]        k;
  logic [pN-1:0]        n_q;
  logic [2:0]           trunc_q;
  logic [MW-1:0]        p1_q, p2_q, p3_q, p4_q;
  logic signed [AW-1:0] acc_q;

  logic [XW-1:0]        ext, sh;
  logic                 trunc_dig;
  booth_digit_t         dig;
  logic [MW-1:0]        msel;
  logic signed [AW-1:0] acc_sh, mext, acc_nxt;

  // Extended multiplier {zeros, N, 0}; the current digit sits at bit 3k
  assign ext       = XW'({n_q, 1'b0});
  assign sh        = ext >> (3 * k);
  assign trunc_dig = (32'(trunc_q) > 32'(k));

  booth8_digit_sel u_dsel (
    .raw   (sh[3:0]),
    .trunc (trunc_dig),
    .dig   (dig)
  );

  always_comb begin
    msel = '0;
    case (dig.mag)
      3'd1:    msel = p1_q;
      3'd2:    msel = p2_q;
      3'd3:    msel = p3_q;
      3'd4:    msel = p4_q;
      default: msel = '0;
    endcase
  end

  assign mext    = $signed({{(AW-MW){1'b0}}, msel});
  assign acc_sh  = acc_q <<< 3;
  assign acc_nxt = dig.neg ? (acc_sh - mext) : (acc_sh + mext);

  // Ld restarts from any state, so an in-flight operation is silently dropped
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      k       <= '0;
      n_q     <= '0;
      trunc_q <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      p4_q    <= '0;
      acc_q   <= '0;
      P       <= '0;
      Valid   <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      Valid <= 1'b0;
      if (Ld) begin
        state   <= RUN;
        k       <= K_LAST;
        n_q     <= N;
        trunc_q <= Trunc;
        p1_q    <= P1;
        p2_q    <= P2;
        p3_q    <= P3;
        p4_q    <= P4;
        acc_q   <= '0;
        Busy    <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            acc_q <= acc_nxt;
            if (k == '0) begin
              P     <= acc_nxt[2*pN-1:0];
              Valid <= 1'b1;
              Busy  <= 1'b0;
              state <= IDLE;
            end else begin
              k <= k - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth8_seq_mult.sv
// Randomized self-checking bench for booth8_seq_mult against an arithmetic model.
module tb_booth8_seq_mult;

  logic        Clk = 1'b0;
  logic        Rst, Ld;
  logic [15:0] N;
  logic [19:0] P1, P2, P3, P4;
  logic [2:0]  Trunc;
  logic [31:0] P;
  logic        Valid, Busy;

  int checks = 0;
  int errors = 0;

  booth8_seq_mult #(.pN(16)) dut (
    .Clk(Clk), .Rst(Rst), .Ld(Ld), .N(N),
    .P1(P1), .P2(P2), .P3(P3), .P4(P4),
    .Trunc(Trunc), .P(P), .Valid(Valid), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Dropping the low T Booth digits replaces N by N - (N mod 8^T) + 8^T * N[3T-1]
  function automatic logic [31:0] ref_p(input logic [15:0] m, input logic [15:0] n,
                                        input logic [2:0] t);
    longint unsigned nt, w, lo;
    if (t == 0) nt = 64'(n);
    else begin
      w  = 64'd1 << (3 * t);
      lo = 64'(n) % w;
      nt = 64'(n) - lo + ((((64'(n) >> (3 * t - 1)) & 64'd1) != 0) ? w : 64'd0);
    end
    return 32'(64'(m) * nt);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ops(input logic [15:0] m, input logic [15:0] n, input logic [2:0] t);
    N     = n;
    Trunc = t;
    P1    = {4'd0, m};
    P2    = {4'd0, m} << 1;
    P3    = {4'd0, m} + ({4'd0, m} << 1);
    P4    = {4'd0, m} << 2;
  endtask

  task automatic scramble();
    N = 16'($urandom); Trunc = 3'($urandom);
    P1 = 20'($urandom); P2 = 20'($urandom); P3 = 20'($urandom); P4 = 20'($urandom);
  endtask

  // Ld for one cycle, then wait (bounded) for Valid; counts Busy samples before it
  task automatic run_op(input logic [15:0] m, input logic [15:0] n, input logic [2:0] t,
                        output logic [31:0] p, output int lat, output int bcnt);
    set_ops(m, n, t);
    Ld = 1'b1;
    tick();
    Ld = 1'b0;
    scramble();
    lat  = -1;
    p    = 'x;
    bcnt = Busy ? 1 : 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (Valid) begin
        lat = c;
        p   = P;
        break;
      end
      if (Busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; Ld = 1'b1; set_ops(16'd3, 16'd5, 3'd0);
    tick(); tick();
    Ld = 1'b0; Rst = 1'b0;
    checks += 3;
    if (P !== 32'd0) begin errors++; $display("FAIL reset_P got %0h exp 0", P); end
    if (Valid !== 1'b0) begin errors++; $display("FAIL reset_Valid got %b exp 0", Valid); end
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_Busy got %b exp 0", Busy); end
  endtask

  task automatic test_basic();
    logic [31:0] p; int lat, bcnt;
    run_op(16'd3, 16'd5, 3'd0, p, lat, bcnt);
    checks += 3;
    if (lat !== 6) begin errors++; $display("FAIL basic_latency got %0d exp 6", lat); end
    if (p !== 32'd15) begin errors++; $display("FAIL basic_P got %0d exp 15", p); end
    if (bcnt !== 6) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 6", bcnt); end
    tick();
    checks += 3;
    if (Valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b exp 0", Valid); end
    if (P !== 32'd15) begin errors++; $display("FAIL basic_P_hold got %0d exp 15", P); end
    if (Busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b exp 0", Busy); end
  endtask

  task automatic test_max();
    logic [31:0] p; int lat, bcnt;
    run_op(16'hFFFF, 16'hFFFF, 3'd0, p, lat, bcnt);
    checks += 2;
    if (lat !== 6) begin errors++; $display("FAIL max_latency got %0d exp 6", lat); end
    if (p !== 32'hFFFE0001) begin errors++; $display("FAIL max_P got %0h exp fffe0001", p); end
  endtask

  task automatic test_trunc();
    logic [31:0] p; int lat, bcnt;
    logic [15:0] m, n; logic [2:0] t;
    run_op(16'd1, 16'd7, 3'd0, p, lat, bcnt);
    checks++;
    if (p !== 32'd7) begin errors++; $display("FAIL trunc0_P got %0d exp 7", p); end
    run_op(16'd1, 16'd7, 3'd1, p, lat, bcnt);
    checks++;
    if (p !== 32'd8) begin errors++; $display("FAIL trunc1_P got %0d exp 8", p); end
    run_op(16'd1, 16'd7, 3'd7, p, lat, bcnt);
    checks++;
    if (p !== 32'd0) begin errors++; $display("FAIL trunc7_P got %0d exp 0", p); end
    for (int i = 0; i < 40; i++) begin
      m = 16'($urandom); n = 16'($urandom); t = 3'($urandom);
      run_op(m, n, t, p, lat, bcnt);
      checks++;
      if (p !== ref_p(m, n, t) || lat !== 6) begin
        errors++;
        $display("FAIL trunc_rand m=%0h n=%0h t=%0d got %0h lat %0d exp %0h lat 6",
                 m, n, t, p, lat, ref_p(m, n, t));
      end
    end
  endtask

  task automatic test_abort();
    int vcnt = 0, lat = -1;
    logic [31:0] p = 'x;
    set_ops(16'd3, 16'd5, 3'd0);
    Ld = 1'b1; tick(); Ld = 1'b0; scramble();
    for (int c = 1; c <= 2; c++) begin
      tick();
      if (Valid) vcnt++;
    end
    set_ops(16'd2, 16'd4, 3'd0);
    Ld = 1'b1; tick(); Ld = 1'b0; scramble();
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (Valid) begin
        vcnt++;
        if (lat < 0) begin lat = c; p = P; end
      end
    end
    checks += 3;
    if (vcnt !== 1) begin errors++; $display("FAIL abort_valid_count got %0d exp 1", vcnt); end
    if (lat !== 6) begin errors++; $display("FAIL abort_latency got %0d exp 6", lat); end
    if (p !== 32'd8) begin errors++; $display("FAIL abort_P got %0d exp 8", p); end
  endtask

  task automatic test_reset_mid();
    int vcnt = 0;
    logic [31:0] p; int lat, bcnt;
    set_ops(16'd100, 16'd200, 3'd0);
    Ld = 1'b1; tick(); Ld = 1'b0; scramble();
    tick(); tick();
    Rst = 1'b1; tick(); Rst = 1'b0;
    checks += 3;
    if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_Busy got %b exp 0", Busy); end
    if (P !== 32'd0) begin errors++; $display("FAIL rstmid_P got %0h exp 0", P); end
    if (Valid !== 1'b0) begin errors++; $display("FAIL rstmid_Valid got %b exp 0", Valid); end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (Valid) vcnt++;
    end
    checks++;
    if (vcnt !== 0) begin errors++; $display("FAIL rstmid_stray_valid got %0d exp 0", vcnt); end
    run_op(16'd100, 16'd200, 3'd0, p, lat, bcnt);
    checks += 2;
    if (lat !== 6) begin errors++; $display("FAIL rstmid_after_latency got %0d exp 6", lat); end
    if (p !== 32'd20000) begin errors++; $display("FAIL rstmid_after_P got %0d exp 20000", p); end
  endtask

  // Each new Ld is issued in the Valid cycle of the previous operation
  task automatic test_back_to_back();
    logic [15:0] mq[$], nq[$];
    logic [15:0] m, n;
    logic [31:0] exp_p;
    int lat;
    m = 16'($urandom); n = 16'($urandom);
    mq.push_back(m); nq.push_back(n);
    set_ops(m, n, 3'd0);
    Ld = 1'b1; tick(); Ld = 1'b0; scramble();
    for (int i = 0; i < 1000; i++) begin
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
        tick();
        if (Valid) begin lat = c; break; end
      end
      checks++;
      if (lat !== 6) begin
        errors++;
        $display("FAIL b2b_latency op %0d got %0d exp 6", i, lat);
        break;
      end
      m = mq.pop_front(); n = nq.pop_front();
      exp_p = ref_p(m, n, 3'd0);
      checks++;
      if (P !== exp_p) begin
        errors++;
        $display("FAIL b2b_P op %0d m=%0h n=%0h got %0h exp %0h", i, m, n, P, exp_p);
      end
      if (i < 999) begin
        m = 16'($urandom); n = 16'($urandom);
        mq.push_back(m); nq.push_back(n);
        set_ops(m, n, 3'd0);
        Ld = 1'b1; tick(); Ld = 1'b0; scramble();
      end
    end
  endtask

  initial begin
    Rst = 1'b0; Ld = 1'b0;
    set_ops(16'd0, 16'd0, 3'd0);
    test_reset();
    test_basic();
    test_max();
    test_trunc();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
